// File: rtl/breakout_game_ctrl.sv
// Purpose : game-flow sequencer for breakout (serve/play/pause/level/lives/game-over).
// Latency : every output is registered and updates on the edge that samples frame_tick_i.
// Backpressure: none; inputs are sampled pulses/levels and outputs are frame-rate status.
//
// Ports
//   clock_i        pixel clock
//   reset_n_i      asynchronous active-low reset
//   frame_tick_i   one-cycle pulse at the last pixel of each frame
//   launch_n_i     launch button, active-low, asynchronous
//   ball_lost_i    one-cycle pulse, ball reached the bottom row
//   wall_empty_i   level, all bricks gone
//   ball_hold_o    ball parked on the paddle
//   ball_run_o     ball free to advance
//   wall_reload_o  one-clock pulse, restore all bricks
//   lives_o        remaining lives
//   level_o        current level, 0-based
//   speed_o        ball step per frame (level + 1)
//   game_over_o    end-of-game screen selected
//   state_o        FSM state code, for debug
module breakout_game_ctrl #(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int PAUSE_FRAMES = 90,
    parameter int MAX_LEVEL    = 3
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic       frame_tick_i,
    input  logic       launch_n_i,
    input  logic       ball_lost_i,
    input  logic       wall_empty_i,
    output logic       ball_hold_o,
    output logic       ball_run_o,
    output logic       wall_reload_o,
    output logic [2:0] lives_o,
    output logic [1:0] level_o,
    output logic [1:0] speed_o,
    output logic       game_over_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_LOST  = 3'd3,
        S_CLEAR = 3'd4,
        S_OVER  = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [2:0] lives_q, lives_d;
    logic [1:0] level_q, level_d;
    logic [1:0] speed_q, speed_d;
    logic       hold_q, hold_d;
    logic       run_q, run_d;
    logic       reload_q, reload_d;
    logic       over_q, over_d;
    logic       lost_q, lost_d;
    // Two-flop synchroniser for the button, then a per-frame sample for edge detection.
    logic       launch_meta_q, launch_sync_q;
    logic       launch_prev_q, launch_prev_d;

    logic       press;
    logic       lost_hit;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        lives_d       = lives_q;
        level_d       = level_q;
        reload_d      = 1'b0;
        // Button counts as a press only on a released->pressed change between frame samples.
        press         = frame_tick_i & launch_prev_q & ~launch_sync_q;
        launch_prev_d = frame_tick_i ? launch_sync_q : launch_prev_q;
        // A loss arriving on the tick cycle itself still belongs to this frame.
        lost_hit      = lost_q | ball_lost_i;
        lost_d        = (state_q == S_PLAY) && !frame_tick_i && lost_hit;

        if (frame_tick_i) begin
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (press) begin
                        state_d  = S_SERVE;
                        lives_d  = 3'(LIVES);
                        level_d  = 2'd0;
                        reload_d = 1'b1;
                    end
                end
                S_SERVE: begin
                    timer_d = timer_q + 8'd1;
                    if (press || timer_q == 8'(SERVE_FRAMES - 1)) state_d = S_PLAY;
                end
                S_PLAY: begin
                    // A cleared wall wins over a simultaneous lost ball.
                    if (wall_empty_i) begin
                        state_d = S_CLEAR;
                    end else if (lost_hit) begin
                        if (lives_q == 3'd1) begin
                            state_d = S_OVER;
                            lives_d = 3'd0;
                        end else begin
                            state_d = S_LOST;
                            lives_d = lives_q - 3'd1;
                        end
                    end
                end
                S_LOST: begin
                    timer_d = timer_q + 8'd1;
                    if (timer_q == 8'(PAUSE_FRAMES - 1)) state_d = S_SERVE;
                end
                S_CLEAR: begin
                    timer_d = timer_q + 8'd1;
                    if (timer_q == 8'(PAUSE_FRAMES - 1)) begin
                        state_d  = S_SERVE;
                        reload_d = 1'b1;
                        if (level_q < 2'(MAX_LEVEL - 1)) level_d = level_q + 2'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (state_d != state_q) timer_d = 8'd0;
        end

        hold_d  = (state_d == S_IDLE) || (state_d == S_SERVE) ||
                  (state_d == S_LOST) || (state_d == S_CLEAR);
        run_d   = (state_d == S_PLAY);
        over_d  = (state_d == S_OVER);
        speed_d = level_d + 2'd1;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= S_IDLE;
            timer_q       <= 8'd0;
            lives_q       <= 3'(LIVES);
            level_q       <= 2'd0;
            speed_q       <= 2'd1;
            hold_q        <= 1'b1;
            run_q         <= 1'b0;
            reload_q      <= 1'b0;
            over_q        <= 1'b0;
            lost_q        <= 1'b0;
            launch_meta_q <= 1'b1;
            launch_sync_q <= 1'b1;
            launch_prev_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            speed_q       <= speed_d;
            hold_q        <= hold_d;
            run_q         <= run_d;
            reload_q      <= reload_d;
            over_q        <= over_d;
            lost_q        <= lost_d;
            launch_meta_q <= launch_n_i;
            launch_sync_q <= launch_meta_q;
            launch_prev_q <= launch_prev_d;
        end
    end

    assign ball_hold_o   = hold_q;
    assign ball_run_o    = run_q;
    assign wall_reload_o = reload_q;
    assign lives_o       = lives_q;
    assign level_o       = level_q;
    assign speed_o       = speed_q;
    assign game_over_o   = over_q;
    assign state_o       = state_q;

endmodule
